// File: rtl/phy_pkg.sv
// Shared PHY definitions for the receive lane.
// Holds the comma symbol and the aligner state encoding.
package phy_pkg;

    localparam logic [7:0] COMMA_K285 = 8'hBC;

    typedef enum logic [1:0] {
        HUNT,
        LOCKING,
        LOCKED
    } rx_align_state_t;

    function automatic logic [7:0] sat_inc8(
        input logic [7:0] v
    );
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_rx_align_if.sv
// Lane-side signals of the byte aligner.
// master drives the serial bit, slave returns bytes.
interface serial_rx_align_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );

endinterface

// File: rtl/rx_shift_comma.sv
// Serial shift window with comma detect.
// sr_next is the byte ending on the current bit.
module rx_shift_comma
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_K285
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] sr_next,
    output logic       is_comma
);

    // Only seven stored bits ever reach the next window.
    logic [6:0] sr;

    assign sr_next  = {sr, data_in};
    assign is_comma = (sr_next == COMMA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= sr_next[6:0];
        end
    end

endmodule

// File: rtl/serial_rx_align.sv
// Comma-hunting byte aligner for one serial lane.
// Locks on repeated aligned commas, drops on comma starvation.
module serial_rx_align
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA      = COMMA_K285,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic               clk,
    input  logic               reset,
    serial_rx_align_if.slave   rx
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [7:0] GAP_N  = 8'(MAX_GAP);

    logic [7:0]      sr_next;
    logic            is_comma;
    rx_align_state_t state;
    logic [2:0]      bit_cnt;
    logic [3:0]      comma_cnt;
    logic [7:0]      gap_cnt;
    logic            boundary;
    logic [3:0]      comma_nxt;
    logic            gap_hit;

    rx_shift_comma #(
        .COMMA (COMMA)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .data_in  (rx.data_in),
        .sr_next  (sr_next),
        .is_comma (is_comma)
    );

    assign boundary  = (bit_cnt == 3'd7);
    assign comma_nxt = comma_cnt + 4'd1;

    // Gap test uses the counter as it stood before this boundary.
    assign gap_hit = (GAP_N != 8'd0)
                   && !is_comma
                   && (gap_cnt + 8'd1 == GAP_N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= HUNT;
            bit_cnt        <= '0;
            comma_cnt      <= '0;
            gap_cnt        <= '0;
            rx.data_out    <= '0;
            rx.valid_out   <= 1'b0;
            rx.byte_strobe <= 1'b0;
            rx.active      <= 1'b0;
        end else begin
            rx.byte_strobe <= 1'b0;
            unique case (state)
                HUNT: begin
                    rx.valid_out <= 1'b0;
                    rx.active    <= 1'b0;
                    if (is_comma) begin
                        bit_cnt   <= '0;
                        comma_cnt <= 4'd1;
                        state     <= LOCKING;
                    end
                end
                LOCKING: begin
                    bit_cnt      <= bit_cnt + 3'd1;
                    rx.valid_out <= 1'b0;
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_nxt;
                            if (comma_nxt == LOCK_N) begin
                                state     <= LOCKED;
                                rx.active <= 1'b1;
                                gap_cnt   <= '0;
                            end
                        end else begin
                            comma_cnt <= '0;
                            state     <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (gap_hit) begin
                            state        <= HUNT;
                            rx.active    <= 1'b0;
                            rx.valid_out <= 1'b0;
                            comma_cnt    <= '0;
                            gap_cnt      <= '0;
                        end else begin
                            rx.data_out    <= sr_next;
                            rx.valid_out   <= !is_comma;
                            rx.byte_strobe <= 1'b1;
                            gap_cnt        <= is_comma ? 8'd0
                                            : sat_inc8(gap_cnt);
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_align.sv
// Directed plus random bench for serial_rx_align.
// Reference model tracks alignment as a cycle offset.
module tb_serial_rx_align;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   strobes;
    int   vstrobes;

    serial_rx_align_if rx ();

    serial_rx_align dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: 0 hunt, 1 locking, 2 locked
    int         m_state;
    int         m_cyc;
    int         m_anchor;
    int         m_nc;
    int         m_gap;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_val;
    logic       m_stb;
    logic       m_act;

    task automatic model_reset();
        m_state  = 0;
        m_cyc    = 0;
        m_anchor = 0;
        m_nc     = 0;
        m_gap    = 0;
        m_win    = 8'h00;
        m_data   = 8'h00;
        m_val    = 1'b0;
        m_stb    = 1'b0;
        m_act    = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        bit aligned;
        m_cyc   = m_cyc + 1;
        m_win   = {m_win[6:0], b};
        m_stb   = 1'b0;
        aligned = ((m_cyc - m_anchor) % 8) == 0;
        case (m_state)
            0: begin
                m_val = 1'b0;
                m_act = 1'b0;
                if (m_win == 8'hBC) begin
                    m_state  = 1;
                    m_anchor = m_cyc;
                    m_nc     = 1;
                end
            end
            1: begin
                if (aligned) begin
                    if (m_win == 8'hBC) begin
                        m_nc = m_nc + 1;
                        if (m_nc == 4) begin
                            m_state = 2;
                            m_act   = 1'b1;
                            m_gap   = 0;
                        end
                    end else begin
                        m_state = 0;
                        m_nc    = 0;
                    end
                end
            end
            default: begin
                if (aligned) begin
                    if (m_win != 8'hBC && m_gap + 1 == 64) begin
                        m_state = 0;
                        m_nc    = 0;
                        m_act   = 1'b0;
                        m_val   = 1'b0;
                    end else begin
                        m_data = m_win;
                        m_val  = (m_win != 8'hBC);
                        m_stb  = 1'b1;
                        m_gap  = (m_win == 8'hBC) ? 0 : m_gap + 1;
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk(tag,
            {21'd0, rx.active, rx.byte_strobe,
             rx.valid_out, rx.data_out},
            {21'd0, m_act, m_stb, m_val, m_data});
    endtask

    task automatic step(input logic b);
        rx.data_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        chk_model("cycle");
        strobes  += int'(rx.byte_strobe);
        vstrobes += int'(rx.byte_strobe && rx.valid_out);
    endtask

    task automatic send(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic commas(input int n);
        for (int i = 0; i < n; i++) send(8'hBC);
    endtask

    logic [7:0] rb;

    initial begin
        tests      = 0;
        fails      = 0;
        strobes    = 0;
        vstrobes   = 0;
        rx.data_in = 1'b0;
        reset      = 1'b1;
        model_reset();

        // reset held with random data
        for (int i = 0; i < 6; i++) begin
            rx.data_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold", {21'd0, rx.active, rx.byte_strobe,
                             rx.valid_out, rx.data_out}, 32'd0);
        end
        @(negedge clk);
        rx.data_in = 1'b0;
        reset      = 1'b0;
        #1;
        chk("rst_release", {21'd0, rx.active, rx.byte_strobe,
                            rx.valid_out, rx.data_out}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0);

        // lock then data
        for (int i = 0; i < 3; i++) step(1'($urandom));
        commas(3);
        chk("pre_lock", {31'd0, rx.active}, 32'd0);
        send(8'hBC);
        chk("lock_active", {31'd0, rx.active}, 32'd1);
        chk("lock_nostb", {31'd0, rx.byte_strobe}, 32'd0);
        send(8'h5A);
        chk("d5a", {24'd0, rx.data_out}, 32'h5A);
        chk("d5a_val", {31'd0, rx.valid_out}, 32'd1);
        chk("d5a_stb", {31'd0, rx.byte_strobe}, 32'd1);
        step(1'b0);
        chk("stb_pulse", {31'd0, rx.byte_strobe}, 32'd0);
        chk("val_hold", {31'd0, rx.valid_out}, 32'd1);
        for (int i = 6; i >= 0; i--) step(rb_const3c(i));
        chk("d3c", {24'd0, rx.data_out}, 32'h3C);

        // idle commas in lock
        send(8'hBC);
        chk("idle1", {22'd0, rx.byte_strobe,
                      rx.valid_out, rx.data_out}, 32'h2BC);
        send(8'h11);
        chk("idle2", {22'd0, rx.byte_strobe,
                      rx.valid_out, rx.data_out}, 32'h311);
        send(8'hBC);
        chk("idle3", {22'd0, rx.byte_strobe,
                      rx.valid_out, rx.data_out}, 32'h2BC);

        // watchdog
        vstrobes = 0;
        for (int i = 0; i < 63; i++) send(8'hA5);
        chk("wd_63_active", {31'd0, rx.active}, 32'd1);
        send(8'hA5);
        chk("wd_valid_strobes", vstrobes, 32'd63);
        chk("wd_drop", {29'd0, rx.active, rx.valid_out,
                        rx.byte_strobe}, 32'd0);

        // failed lock then relock
        commas(3);
        send(8'h00);
        chk("fail_lock", {31'd0, rx.active}, 32'd0);
        commas(4);
        chk("relock", {31'd0, rx.active}, 32'd1);

        // unaligned comma inside data
        send(8'h0B);
        send(8'hC0);
        chk("unaligned", {24'd0, rx.data_out}, 32'hC0);
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            send(rb);
            chk("rand_byte", {24'd0, rx.data_out}, {24'd0, rb});
        end
        chk("still_locked", {31'd0, rx.active}, 32'd1);

        // reset at bit 3 of a byte
        for (int i = 0; i < 3; i++) step(1'($urandom));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async", {21'd0, rx.active, rx.byte_strobe,
                          rx.valid_out, rx.data_out}, 32'd0);
        @(posedge clk);
        #1;
        chk_model("rst_mid");
        @(negedge clk);
        reset    = 1'b0;
        strobes  = 0;
        send(8'h5A);
        chk("post_rst_nostb", strobes, 32'd0);
        commas(3);
        chk("post_rst_3bc", {31'd0, rx.active}, 32'd1 - 32'd1);
        send(8'hBC);
        chk("post_rst_lock", {31'd0, rx.active}, 32'd1);
        send(8'h77);
        chk("post_rst_data", {24'd0, rx.data_out}, 32'h77);

        // free-running random bits against the model
        for (int i = 0; i < 600; i++) step(1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic rb_const3c(input int i);
        logic [7:0] v;
        v = 8'h3C;
        return v[i];
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
